udp_rx_ram_writer: RTL and testbench
====================================

Name: udp_rx_ram_writer

Overview:
- Sits directly upstream of the 8-bit x 2048 UDP receive simple-dual-port RAM.
- Accepts the UDP payload byte stream from the UDP RX parser and writes frames into the RAM, which is used as a circular buffer.
- Commits good frames as (start address, length) descriptors for the downstream reader.
- Rolls back errored, truncated or overflowing frames so they never become visible; reclaims space when the reader releases it.

Parameters:
- ADDR_WIDTH, 11, RAM address width; buffer depth = 2**ADDR_WIDTH bytes.
- DESC_DEPTH, 4, descriptor FIFO depth (power of 2, 2..16).
- CNT_WIDTH, 16, width of the dropped-frame counter.

Ports:
- clk  in  1  single clock, shared with the RAM write port.
- rst  in  1  reset; synchronous, active-high.
- s_data  in  8  payload byte.
- s_valid  in  1  byte valid; no backpressure (the stream cannot stall).
- s_sop  in  1  first byte of frame, qualified by s_valid.
- s_eop  in  1  last byte of frame, qualified by s_valid.
- s_err  in  1  frame bad (checksum/length error), sampled with s_eop.
- ram_wr_data  out  8  to RAM wr_data.
- ram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr.
- ram_wr_en  out  1  to RAM wr_en.
- desc_valid  out  1  descriptor available.
- desc_ready  in  1  reader accepts descriptor.
- desc_addr  out  ADDR_WIDTH  frame start address.
- desc_len  out  ADDR_WIDTH+1  frame length in bytes, 1..2048.
- rel_valid  in  1  reader returns space, one pulse per frame.
- rel_len  in  ADDR_WIDTH+1  bytes released.
- used_bytes  out  ADDR_WIDTH+1  committed, unreleased bytes.
- drop_cnt  out  CNT_WIDTH  dropped frames; saturating.

Behaviour:
- Reset values: all outputs 0; wr_ptr=0; FIFO empty; state IDLE.
- Reset mid-frame discards the frame and all descriptors. rst has priority over every other input.
- Pointers:
  - wr_ptr = committed write pointer.
  - cur_addr = wr_ptr + cur_len, mod 2**ADDR_WIDTH (wraps naturally, no padding).
- State IDLE:
  - s_valid & s_sop: cur_len := 0, the byte is processed as below, go to RECV.
  - s_valid without s_sop: byte ignored.
- State RECV: each s_valid byte is handled as follows.
  - Space check: if used_bytes + cur_len == 2**ADDR_WIDTH, the byte is not written and the state goes to DROP. The same applies on that byte's s_eop.
  - Otherwise:
    - Registered write, 1-cycle latency: at cycle N+1, ram_wr_en=1, ram_wr_addr=cur_addr, ram_wr_data=byte.
    - cur_len increments.
- s_eop in RECV (including sop&eop on the same byte, giving a 1-byte frame):
  - If s_err, or the descriptor FIFO is full: drop.
  - Otherwise commit:
    - push {wr_ptr, cur_len+1} at N+1;
    - wr_ptr += cur_len+1;
    - used_bytes += cur_len+1.
  - Go to IDLE.
- s_sop in RECV without a prior s_eop: the current frame is dropped and the new frame starts on this byte.
- State DROP:
  - Consume bytes without writing until s_eop, then IDLE.
  - s_sop in DROP starts a new frame (RECV).
- Drop action: wr_ptr is unchanged (rollback), drop_cnt += 1 (saturates at all-ones), no descriptor.
- Descriptor FIFO:
  - First-word-fall-through: desc_valid is high whenever it is non-empty, earliest at N+2 after the eop byte.
  - Pop on desc_valid & desc_ready.
  - Push and pop in the same cycle are allowed when full.
- used_bytes update, same cycle: used_bytes := used_bytes + commit_len − (rel_valid ? rel_len : 0).
  - A release larger than used_bytes clamps the result to 0.
  - Commit and release in the same cycle are both applied.
- RAM data is always written at least one cycle before its descriptor becomes visible.

Test Plan:
- 10-byte good frame 0x00..0x09 from reset -> ram writes at addr 0..9, one per cycle, 1 cycle after each input byte; desc {addr=0, len=10}; used_bytes=10.
- Frame with s_err=1 on eop, then a 4-byte good frame -> drop_cnt=1; only one descriptor, {addr=0, len=4}. The second frame overwrites addresses 0..3.
- Fill with two 1000-byte frames (no release), then send a 100-byte frame -> the third frame writes 48 bytes then drops; drop_cnt=1; used_bytes=2000.
- Same setup, release 1000 (rel_valid), send a 100-byte frame -> desc {addr=2000, len=100}; the frame's writes wrap, landing at 2000..2047 then 0..51; used_bytes=1100.
- desc_ready=0, send 5 good 1-byte sop&eop frames -> 4 descriptors held, the 5th is dropped (drop_cnt=1); then desc_ready=1 pops the 4 in order.
- sop at byte 3 of an open frame; also rst asserted mid-frame -> the first frame is dropped and the new frame commits normally. After rst: desc_valid=0, used_bytes=0, drop_cnt=0, and the next frame starts at addr 0.

Source files
------------

// File: rtl/udp_rx_ram_writer.sv
// UDP payload to circular RAM writer: buffers frames, commits good ones as
// (addr, len) descriptors and rolls back errored, truncated or overflowing frames.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | between frames, waiting for a sop byte
//  S_RECV | writing frame bytes at wr_ptr + cur_len
//  S_DROP | frame abandoned, discarding bytes until eop (or a new sop)
module udp_rx_ram_writer #(
    parameter int ADDR_WIDTH = 11,
    parameter int DESC_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    input  logic                  s_sop,
    input  logic                  s_eop,
    input  logic                  s_err,
    output logic [7:0]            ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic                  ram_wr_en,
    output logic                  desc_valid,
    input  logic                  desc_ready,
    output logic [ADDR_WIDTH-1:0] desc_addr,
    output logic [ADDR_WIDTH:0]   desc_len,
    input  logic                  rel_valid,
    input  logic [ADDR_WIDTH:0]   rel_len,
    output logic [ADDR_WIDTH:0]   used_bytes,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam int PW = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int DW = ADDR_WIDTH + LW;
    localparam logic [ADDR_WIDTH+1:0] BUF_BYTES = {2'b01, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [LW-1:0]         cur_len;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [LW-1:0]         used_q;
    logic [CNT_WIDTH-1:0]  drop_q;

    logic                  push_q;
    logic [ADDR_WIDTH-1:0] push_addr_q;
    logic [LW-1:0]         push_len_q;

    logic [DW-1:0]         fifo_mem [DESC_DEPTH];
    logic [PW-1:0]         fifo_rp;
    logic [PW-1:0]         fifo_wp;
    logic [CW-1:0]         fifo_cnt;
    logic [DW-1:0]         fifo_head;

    logic                  sop_byte;
    logic                  frame_byte;
    logic [LW-1:0]         eff_len;
    logic [LW-1:0]         commit_len;
    logic                  space_full;
    logic                  pop;
    logic [CW:0]           fifo_occ;
    logic                  fifo_full;

    logic                  wr_byte;
    logic                  commit;
    logic                  abort;
    logic                  drop_now;

    logic [LW:0]           used_sum;
    logic [LW:0]           rel_amt;
    logic [LW-1:0]         used_nxt;
    logic [CNT_WIDTH:0]    drop_sum;
    logic [CNT_WIDTH-1:0]  drop_nxt;

    // A sop byte always restarts the frame, so its offset is zero whatever cur_len holds.
    assign sop_byte   = s_valid & s_sop;
    assign frame_byte = s_valid & (s_sop | (state == S_RECV));
    assign eff_len    = sop_byte ? '0 : cur_len;
    assign commit_len = eff_len + LW'(1);
    assign space_full = ({1'b0, used_q} + {1'b0, eff_len}) == BUF_BYTES;

    assign desc_valid = (fifo_cnt != '0);
    assign pop        = desc_valid & desc_ready;

    // Occupancy counts the push still in flight; a pop on this edge frees a slot.
    assign fifo_occ   = {1'b0, fifo_cnt} + {{CW{1'b0}}, push_q} - {{CW{1'b0}}, pop};
    assign fifo_full  = fifo_occ >= (CW+1)'(DESC_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (frame_byte) begin
            if (s_eop) begin
                state_nxt = S_IDLE;
            end else if (space_full) begin
                state_nxt = S_DROP;
            end else begin
                state_nxt = S_RECV;
            end
        end else if ((state == S_DROP) && s_valid && s_eop) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        wr_byte  = frame_byte & ~space_full;
        abort    = sop_byte & (state == S_RECV);
        drop_now = frame_byte & (space_full | (s_eop & (s_err | fifo_full)));
        commit   = frame_byte & s_eop & ~space_full & ~s_err & ~fifo_full;
    end

    always_comb begin
        used_sum = {1'b0, used_q} + (commit ? {1'b0, commit_len} : '0);
        rel_amt  = rel_valid ? {1'b0, rel_len} : '0;
        used_nxt = (used_sum > rel_amt) ? LW'(used_sum - rel_amt) : '0;
        drop_sum = {1'b0, drop_q} + (CNT_WIDTH+1)'({1'b0, abort} + {1'b0, drop_now});
        drop_nxt = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_len     <= '0;
            wr_ptr      <= '0;
            used_q      <= '0;
            drop_q      <= '0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            push_q      <= 1'b0;
            push_addr_q <= '0;
            push_len_q  <= '0;
        end else begin
            if (frame_byte) begin
                cur_len <= wr_byte ? commit_len : eff_len;
            end
            ram_wr_en <= wr_byte;
            if (wr_byte) begin
                ram_wr_addr <= wr_ptr + eff_len[ADDR_WIDTH-1:0];
                ram_wr_data <= s_data;
            end
            // The descriptor lands in the FIFO one edge after the last RAM write.
            push_q      <= commit;
            push_addr_q <= wr_ptr;
            push_len_q  <= commit_len;
            if (commit) begin
                wr_ptr <= wr_ptr + commit_len[ADDR_WIDTH-1:0];
            end
            used_q <= used_nxt;
            drop_q <= drop_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_rp  <= '0;
            fifo_wp  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_q) begin
                fifo_wp <= fifo_wp + PW'(1);
            end
            if (pop) begin
                fifo_rp <= fifo_rp + PW'(1);
            end
            fifo_cnt <= fifo_cnt + {{(CW-1){1'b0}}, push_q} - {{(CW-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push_q) begin
            fifo_mem[fifo_wp] <= {push_addr_q, push_len_q};
        end
    end

    assign fifo_head  = fifo_mem[fifo_rp];
    assign desc_addr  = desc_valid ? fifo_head[DW-1:LW] : '0;
    assign desc_len   = desc_valid ? fifo_head[LW-1:0] : '0;
    assign used_bytes = used_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_udp_rx_ram_writer.sv
// Bench for udp_rx_ram_writer: vector table, directed corner sequences and a
// randomized run, all compared against a frame-level reference model.
module tb_udp_rx_ram_writer;

    localparam int AW  = 11;
    localparam int DD  = 4;
    localparam int CNW = 16;
    localparam int BUF = 2048;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_sop = 1'b0;
    logic            s_eop = 1'b0;
    logic            s_err = 1'b0;
    logic [7:0]      ram_wr_data;
    logic [AW-1:0]   ram_wr_addr;
    logic            ram_wr_en;
    logic            desc_valid;
    logic            desc_ready = 1'b0;
    logic [AW-1:0]   desc_addr;
    logic [AW:0]     desc_len;
    logic            rel_valid = 1'b0;
    logic [AW:0]     rel_len = '0;
    logic [AW:0]     used_bytes;
    logic [CNW-1:0]  drop_cnt;

    always #5 clk = ~clk;

    udp_rx_ram_writer #(.ADDR_WIDTH(AW), .DESC_DEPTH(DD), .CNT_WIDTH(CNW)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop), .s_err(s_err),
        .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_addr(desc_addr), .desc_len(desc_len),
        .rel_valid(rel_valid), .rel_len(rel_len),
        .used_bytes(used_bytes), .drop_cnt(drop_cnt)
    );

    // The RAM the writer feeds.
    logic [7:0] tb_ram [BUF];
    always @(posedge clk) if (ram_wr_en) tb_ram[ram_wr_addr] <= ram_wr_data;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level bookkeeping of the circular buffer.
    typedef struct { int addr; int len; int vis; } desc_t;
    desc_t m_q[$];
    int    rel_q[$];
    int    cyc = 0;
    int    m_used = 0, m_wr_ptr = 0, m_drop = 0, m_len = 0;
    bit    m_recv = 0, m_dropping = 0;
    bit    e_we = 0;
    int    e_wa = 0, e_wd = 0;
    bit    rand_mode = 0;

    int    wr_cnt = 0, first_wa = 0, last_wa = 0;
    bit    first_seen = 0;

    function automatic void m_drop_inc();
        if (m_drop < (1 << CNW) - 1) m_drop++;
    endfunction

    task automatic model_edge();
        bit pop;
        int commit_amt;
        cyc++;
        if (rst) begin
            m_used = 0; m_wr_ptr = 0; m_drop = 0; m_len = 0;
            m_recv = 0; m_dropping = 0; e_we = 0;
            m_q.delete();
            return;
        end
        pop = (m_q.size() > 0) && (m_q[0].vis <= cyc - 1) && desc_ready;
        commit_amt = 0;
        e_we = 0;
        if (s_valid) begin
            if (s_sop) begin
                if (m_recv) m_drop_inc();
                m_recv = 1; m_dropping = 0; m_len = 0;
            end
            if (m_recv) begin
                if (m_used + m_len == BUF) begin
                    m_drop_inc();
                    m_recv = 0;
                    m_dropping = !s_eop;
                end else begin
                    e_we = 1;
                    e_wa = (m_wr_ptr + m_len) % BUF;
                    e_wd = int'(s_data);
                    m_len++;
                    if (s_eop) begin
                        if (s_err || (int'(m_q.size()) - int'(pop)) >= DD) begin
                            m_drop_inc();
                        end else begin
                            m_q.push_back('{m_wr_ptr, m_len, cyc + 1});
                            m_wr_ptr = (m_wr_ptr + m_len) % BUF;
                            commit_amt = m_len;
                        end
                        m_recv = 0;
                    end
                end
            end else if (m_dropping && s_eop) begin
                m_dropping = 0;
            end
        end
        if (pop) begin
            if (rand_mode) rel_q.push_back(m_q[0].len);
            void'(m_q.pop_front());
        end
        m_used = m_used + commit_amt - (rel_valid ? int'(rel_len) : 0);
        if (m_used < 0) m_used = 0;
    endtask

    task automatic check_outputs();
        bit exp_dv;
        chk("ram_wr_en", 32'(ram_wr_en), 32'(e_we));
        if (e_we) begin
            chk("ram_wr_addr", 32'(ram_wr_addr), e_wa);
            chk("ram_wr_data", 32'(ram_wr_data), e_wd);
        end
        exp_dv = (m_q.size() > 0) && (m_q[0].vis <= cyc);
        chk("desc_valid", 32'(desc_valid), 32'(exp_dv));
        if (exp_dv) begin
            chk("desc_addr", 32'(desc_addr), m_q[0].addr);
            chk("desc_len", 32'(desc_len), m_q[0].len);
        end
        chk("used_bytes", 32'(used_bytes), m_used);
        chk("drop_cnt", 32'(drop_cnt), m_drop);
    endtask

    task automatic rand_reader();
        desc_ready = 1'($urandom_range(0, 1));
        if (rel_q.size() > 0 && $urandom_range(0, 7) == 0) begin
            rel_valid = 1'b1;
            rel_len = 12'(rel_q.pop_front());
        end else begin
            rel_valid = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (ram_wr_en) begin
            if (!first_seen) begin
                first_wa = int'(ram_wr_addr);
                first_seen = 1;
            end
            last_wa = int'(ram_wr_addr);
            wr_cnt++;
        end
    endtask

    task automatic drive_byte(bit v, bit sop, bit eop, bit err, logic [7:0] d);
        s_valid = v; s_sop = sop; s_eop = eop; s_err = err; s_data = d;
        if (rand_mode) rand_reader();
        cycle();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive_byte(0, 0, 0, 0, 8'h00);
    endtask

    task automatic send_frame(int len, int base, bit err);
        for (int i = 0; i < len; i++)
            drive_byte(1, i == 0, i == len - 1, err && (i == len - 1), 8'(base + i));
    endtask

    task automatic mark();
        wr_cnt = 0; first_seen = 0; first_wa = 0; last_wa = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rel_valid = 1'b0;
        desc_ready = 1'b0;
        rel_q.delete();
        idle(2);
        chk("rst ram_wr_en", 32'(ram_wr_en), 0);
        chk("rst ram_wr_addr", 32'(ram_wr_addr), 0);
        chk("rst ram_wr_data", 32'(ram_wr_data), 0);
        chk("rst desc_valid", 32'(desc_valid), 0);
        chk("rst desc_addr", 32'(desc_addr), 0);
        chk("rst desc_len", 32'(desc_len), 0);
        chk("rst used_bytes", 32'(used_bytes), 0);
        chk("rst drop_cnt", 32'(drop_cnt), 0);
        rst = 1'b0;
    endtask

    typedef struct {
        bit v, sop, eop, err;
        logic [7:0] d;
        bit we; int wa; int wd;
        bit dv; int da; int dl;
        int used; int drop;
    } vec_t;

    vec_t tbl [12];

    initial begin
        for (int i = 0; i < 10; i++)
            tbl[i] = '{1'b1, i == 0, i == 9, 1'b0, 8'(i), 1'b1, i, i, 1'b0, 0, 0, (i == 9) ? 10 : 0, 0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 1'b1, 0, 10, 10, 0};
        tbl[11] = tbl[10];

        do_reset();

        // 10-byte good frame from reset
        for (int i = 0; i < 12; i++) begin
            drive_byte(tbl[i].v, tbl[i].sop, tbl[i].eop, tbl[i].err, tbl[i].d);
            chk($sformatf("tbl[%0d].we", i), 32'(ram_wr_en), 32'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("tbl[%0d].wa", i), 32'(ram_wr_addr), tbl[i].wa);
                chk($sformatf("tbl[%0d].wd", i), 32'(ram_wr_data), tbl[i].wd);
            end
            chk($sformatf("tbl[%0d].dv", i), 32'(desc_valid), 32'(tbl[i].dv));
            if (tbl[i].dv) begin
                chk($sformatf("tbl[%0d].da", i), 32'(desc_addr), tbl[i].da);
                chk($sformatf("tbl[%0d].dl", i), 32'(desc_len), tbl[i].dl);
            end
            chk($sformatf("tbl[%0d].used", i), 32'(used_bytes), tbl[i].used);
            chk($sformatf("tbl[%0d].drop", i), 32'(drop_cnt), tbl[i].drop);
        end

        // errored frame then a good 4-byte frame
        do_reset();
        send_frame(6, 8'h60, 1);
        send_frame(4, 8'hA0, 0);
        idle(2);
        chk("err drop_cnt", 32'(drop_cnt), 1);
        chk("err desc_valid", 32'(desc_valid), 1);
        chk("err desc_addr", 32'(desc_addr), 0);
        chk("err desc_len", 32'(desc_len), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("err ram[%0d]", i), 32'(tb_ram[i]), 32'hA0 + i);
        desc_ready = 1'b1;
        idle(1);
        desc_ready = 1'b0;
        idle(1);
        chk("err single desc", 32'(desc_valid), 0);

        // buffer fill, overflow drop, then release and wrap
        do_reset();
        desc_ready = 1'b1;
        send_frame(1000, 0, 0);
        send_frame(1000, 8'h55, 0);
        mark();
        send_frame(100, 8'h11, 0);
        idle(1);
        chk("ovf writes", wr_cnt, 48);
        chk("ovf last addr", last_wa, 2047);
        chk("ovf drop_cnt", 32'(drop_cnt), 1);
        chk("ovf used", 32'(used_bytes), 2000);
        desc_ready = 1'b0;
        rel_valid = 1'b1; rel_len = 12'd1000;
        idle(1);
        rel_valid = 1'b0;
        mark();
        send_frame(100, 8'h22, 0);
        idle(2);
        chk("wrap writes", wr_cnt, 100);
        chk("wrap first addr", first_wa, 2000);
        chk("wrap last addr", last_wa, 51);
        chk("wrap desc_addr", 32'(desc_addr), 2000);
        chk("wrap desc_len", 32'(desc_len), 100);
        chk("wrap used", 32'(used_bytes), 1100);

        // descriptor FIFO full
        do_reset();
        for (int i = 0; i < 5; i++) drive_byte(1, 1, 1, 0, 8'(8'h10 + i));
        idle(3);
        chk("fifo drop_cnt", 32'(drop_cnt), 1);
        desc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fifo pop%0d valid", i), 32'(desc_valid), 1);
            chk($sformatf("fifo pop%0d addr", i), 32'(desc_addr), i);
            chk($sformatf("fifo pop%0d len", i), 32'(desc_len), 1);
            idle(1);
        end
        chk("fifo empty", 32'(desc_valid), 0);
        desc_ready = 1'b0;

        // sop inside an open frame, then reset mid-frame
        do_reset();
        drive_byte(1, 1, 0, 0, 8'h01);
        drive_byte(1, 0, 0, 0, 8'h02);
        drive_byte(1, 0, 0, 0, 8'h03);
        send_frame(5, 8'h50, 0);
        idle(2);
        chk("abort drop_cnt", 32'(drop_cnt), 1);
        chk("abort desc_addr", 32'(desc_addr), 0);
        chk("abort desc_len", 32'(desc_len), 5);
        drive_byte(1, 1, 0, 0, 8'h40);
        drive_byte(1, 0, 0, 0, 8'h41);
        rst = 1'b1;
        drive_byte(1, 1, 1, 0, 8'h77);
        idle(1);
        rst = 1'b0;
        chk("rst mid desc_valid", 32'(desc_valid), 0);
        chk("rst mid used", 32'(used_bytes), 0);
        chk("rst mid drop_cnt", 32'(drop_cnt), 0);
        mark();
        send_frame(3, 8'h30, 0);
        idle(2);
        chk("post-rst first addr", first_wa, 0);
        chk("post-rst desc_addr", 32'(desc_addr), 0);
        chk("post-rst desc_len", 32'(desc_len), 3);

        // release clamp and commit+release on the same edge
        do_reset();
        send_frame(10, 0, 0);
        rel_valid = 1'b1; rel_len = 12'd50;
        idle(1);
        rel_valid = 1'b0;
        chk("clamp used", 32'(used_bytes), 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin rel_valid = 1'b1; rel_len = 12'd3; end
            drive_byte(1, i == 0, i == 3, 0, 8'(i));
        end
        rel_valid = 1'b0;
        chk("commit+rel used", 32'(used_bytes), 1);

        // randomized traffic with a slow, randomly stalling reader
        do_reset();
        rand_mode = 1;
        for (int f = 0; f < 60; f++) begin
            int len;
            bit err, trunc;
            if (f == 30) begin
                rst = 1'b1;
                rel_q.delete();
                drive_byte(1, 1, 0, 0, 8'($urandom));
                idle(1);
                rst = 1'b0;
            end
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                if ($urandom_range(0, 3) == 0)
                    drive_byte(1, 0, 1'($urandom_range(0, 1)), 0, 8'($urandom));
                else
                    idle(1);
            end
            len   = (f % 5 == 4) ? $urandom_range(1, 4) : $urandom_range(1, 500);
            err   = ($urandom_range(0, 7) == 0);
            trunc = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < len; i++) begin
                if (i > 0 && $urandom_range(0, 7) == 0) idle(1);
                drive_byte(1, i == 0, !trunc && (i == len - 1), err && (i == len - 1), 8'($urandom));
            end
        end
        rand_mode = 0;
        rel_valid = 1'b0;
        desc_ready = 1'b1;
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
